instr_mem_ctrl: RTL and testbench
=================================

# instr_mem_ctrl

Instruction-memory responder on the far side of the fetch stage's program-counter bus. It accepts the 8-bit fetch address each cycle and returns the addressed 9-bit instruction one cycle later. It also owns a valid/ready load port through which the testbench or boot logic writes the program image. While no program is present or a load is in progress, it holds the fetch stage in halt; when a load completes, it pulses a core reset so execution restarts at address 0.

## Interface
- DEPTH, 256: instruction words stored; address width is 8.
- IW, 9: instruction width.
- HALT_WORD, 9'h1FF: word returned for addresses at or beyond the loaded length.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- addr  in  8  fetch address from the program counter.
- instr  out  IW  registered instruction for the address sampled at the previous edge.
- instr_valid  out  1  instr holds a legitimate fetch result.
- core_halt  out  1  drives the fetch stage's halt input.
- core_reset  out  1  one-cycle pulse that drives the fetch stage's reset input.
- load_start  in  1  request to begin loading a program.
- load_len  in  9  number of words to load; sampled with load_start.
- load_valid  in  1  load_data is presented.
- load_data  in  IW  program word.
- load_ready  out  1  block accepts a word this cycle.
- load_done  out  1  one-cycle pulse marking the end of a load.

## Operation
- State machine with four states: EMPTY, LOAD, FLUSH and RUN.
- The block holds three registers: wr_ptr (8 bits), len (9 bits, 0..256) and tgt (9 bits).
- The memory array is not reset. Contents survive reset, but after reset they are unreachable because len=0.

**EMPTY** (entered on reset)
- core_halt=1, load_ready=0.
- load_start with load_len≠0 moves to LOAD and:
  - sets tgt = min(load_len, 256);
  - sets wr_ptr = 0;
  - sets len = 0.
- load_start with load_len=0 is ignored.

**LOAD**
- core_halt=1, load_ready=1.
- A transfer occurs when load_valid && load_ready. On a transfer:
  - mem[wr_ptr] = load_data;
  - wr_ptr = wr_ptr+1, with 8-bit wrap (only reachable when tgt=256);
  - len = len+1.
- The transfer that makes len equal tgt moves to FLUSH.
- load_start is ignored while in LOAD.

**FLUSH** (exactly one cycle)
- core_reset=1, core_halt=1, load_done=1.
- Next state is RUN, unconditionally.

**RUN**
- core_halt=0, load_ready=0.
- Each edge: instr <= (addr < len) ? mem[addr] : HALT_WORD, and instr_valid <= 1.
- load_start with load_len≠0 moves to LOAD, using the same register updates as in EMPTY. The previous program is overwritten in place, and len restarts from 0.

**Outside RUN**
- Each edge: instr <= 0, instr_valid <= 0.

**Output decode**
- core_halt, core_reset, load_ready and load_done are decoded from the current state (Moore outputs).

## Timing
- Reset values: instr=0, instr_valid=0, core_halt=1, core_reset=0, load_ready=0, load_done=0, state=EMPTY, len=0, wr_ptr=0.
- Read latency is one cycle: addr sampled at edge k appears on instr after edge k.
- First valid instruction:
  - the final load transfer happens at edge N;
  - FLUSH occupies cycle N..N+1, with core_reset high during it;
  - state is RUN after edge N+1;
  - instr_valid=1 after edge N+2, carrying the word at the address the fetch stage presented after its reset (0).
- Load throughput is one word per cycle while load_valid is held high. A tgt-word load takes tgt cycles plus 1 FLUSH cycle.
- Simultaneous reset and any other event: reset wins.
- Reset mid-load: return to EMPTY with len=0. Any later RUN requires a fresh complete load.
- load_start in the same cycle that RUN samples addr: that sample still completes (instr_valid=1 after that edge). From the following edge, instr=0 and instr_valid=0.
- addr is ignored outside RUN.

## Test plan
- **Reset and idle:** assert reset for 2 cycles, then idle 5 cycles → core_halt=1, instr_valid=0, instr=0, load_ready=0 throughout.
- **Basic load:** load_len=4 with words 9'h011, 9'h022, 9'h033, 9'h044, load_valid held high → load_ready high for 4 cycles, then one cycle with core_reset=1 and load_done=1, then core_halt=0. Driving addr 0..3 returns 9'h011..9'h044, each one cycle after its address.
- **Out-of-range read:** after the 4-word load, addr=4 and addr=255 → instr=9'h1FF.
- **Backpressured source:** load_len=3 with load_valid toggled 1,0,0,1,0,1 → exactly 3 writes, wr_ptr ends at 3, and FLUSH occurs the cycle after the third transfer.
- **Full-size load:** load_len=300 (clamped to 256) with data=index → 256 transfers then FLUSH. Reads of addr 255 → 9'h0FF; addr 0 → 9'h000.
- **Reset during load:** reset asserted after 2 of 5 words → EMPTY, core_halt=1. A following 2-word load (9'h155, 9'h0AA) then reads back 9'h155, 9'h0AA at addresses 0 and 1, and addr=2 → 9'h1FF.
- **Ignored starts:** load_len=0 in EMPTY, and load_start pulsed during LOAD → no state change and no change to tgt.

Source files
------------

// File: rtl/instr_mem_ctrl.sv
// Instruction-memory responder: one-cycle registered fetch port plus a valid/ready
// program-load port that halts the core while loading and pulses its reset afterwards.
module instr_mem_ctrl #(
  parameter int           DEPTH     = 256,
  parameter int           IW        = 9,
  parameter logic [IW-1:0] HALT_WORD = 9'h1FF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  output logic [IW-1:0]              instr,
  output logic                       instr_valid,
  output logic                       core_halt,
  output logic                       core_reset,
  input  logic                       load_start,
  input  logic [$clog2(DEPTH):0]     load_len,
  input  logic                       load_valid,
  input  logic [IW-1:0]              load_data,
  output logic                       load_ready,
  output logic                       load_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {EMPTY, LOAD, FLUSH, RUN} state_t;

  state_t          state;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     len;
  logic [AW:0]     tgt;
  logic [IW-1:0]   mem [DEPTH];

  logic            xfer;
  logic            start_ok;

  assign xfer     = (state == LOAD) && load_valid;
  assign start_ok = load_start && (load_len != '0);

  assign core_halt  = (state != RUN);
  assign core_reset = (state == FLUSH);
  assign load_done  = (state == FLUSH);
  assign load_ready = (state == LOAD);

  // Array is deliberately not reset; len=0 after reset hides stale contents.
  always_ff @(posedge clk) begin
    if (!reset && xfer)
      mem[wr_ptr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EMPTY;
      wr_ptr      <= '0;
      len         <= '0;
      tgt         <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      if (state == RUN) begin
        instr       <= ({1'b0, addr} < len) ? mem[addr] : HALT_WORD;
        instr_valid <= 1'b1;
      end else begin
        instr       <= '0;
        instr_valid <= 1'b0;
      end

      case (state)
        EMPTY, RUN: begin
          if (start_ok) begin
            state  <= LOAD;
            tgt    <= (load_len > FULL) ? FULL : load_len;
            wr_ptr <= '0;
            len    <= '0;
          end
        end
        LOAD: begin
          if (load_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            len    <= len + 1'b1;
            if (len + 1'b1 == tgt)
              state <= FLUSH;
          end
        end
        FLUSH: state <= RUN;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Randomized bench for instr_mem_ctrl against a transaction-level model of the
// loaded program image (word array + loaded length).
module tb_instr_mem_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] addr;
  logic [8:0] instr;
  logic       instr_valid, core_halt, core_reset;
  logic       load_start;
  logic [8:0] load_len;
  logic       load_valid;
  logic [8:0] load_data;
  logic       load_ready, load_done;

  instr_mem_ctrl dut (
    .clk(clk), .reset(reset), .addr(addr), .instr(instr), .instr_valid(instr_valid),
    .core_halt(core_halt), .core_reset(core_reset), .load_start(load_start),
    .load_len(load_len), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [8:0] mmem [256];
  int         mlen = 0;
  bit         running = 0;
  logic [8:0] words [256];
  bit         pattern [6] = '{1, 0, 0, 1, 0, 1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] model_rd(input logic [7:0] a);
    return (int'(a) < mlen) ? mmem[a] : 9'h1FF;
  endfunction

  task automatic read_chk(input logic [7:0] a);
    addr = a;
    tick();
    check("rd_data", instr, model_rd(a));
    check("rd_valid", instr_valid, 1);
    check("rd_halt", core_halt, 0);
  endtask

  task automatic halted_chk(input string tag);
    check({tag, "_halt"}, core_halt, 1);
    check({tag, "_ready"}, load_ready, 0);
    check({tag, "_ivld"}, instr_valid, 0);
    check({tag, "_instr"}, instr, 0);
    check({tag, "_done"}, load_done, 0);
  endtask

  // mode 0: valid always high, 1: random valid, 2: fixed 1,0,0,1,0,1 pattern.
  // abort_at >= 0 asserts reset at the cycle that would carry that transfer.
  task automatic do_load(input int req_len, input int mode, input int abort_at);
    int         tgt;
    int         cnt;
    int         cyc;
    bit         v;
    logic [7:0] a;
    tgt = (req_len > 256) ? 256 : req_len;
    cnt = 0;
    cyc = 0;
    a = 8'($urandom);
    addr = a;
    load_start = 1'b1;
    load_len = 9'(req_len);
    tick();
    load_start = 1'b0;
    if (running) check("start_last_rd", instr, model_rd(a));
    running = 0;
    while (cnt < tgt && cyc < 4 * tgt + 20) begin
      check("ld_ready", load_ready, 1);
      check("ld_halt", core_halt, 1);
      check("ld_creset", core_reset, 0);
      check("ld_ivld", instr_valid, (cyc == 0 && instr_valid));
      if (cyc > 0) check("ld_ivld0", instr_valid, 0);
      v = (mode == 0) ? 1'b1 : (mode == 2) ? pattern[cyc % 6] : 1'($urandom_range(0, 1));
      load_valid = v;
      load_data = words[cnt];
      load_start = ($urandom_range(0, 3) == 0);
      load_len = 9'($urandom);
      addr = 8'($urandom);
      if (v && cnt == abort_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load_valid = 1'b0;
        load_start = 1'b0;
        halted_chk("abort");
        mlen = 0;
        return;
      end
      tick();
      if (v) begin
        mmem[cnt] = words[cnt];
        cnt++;
      end
      cyc++;
    end
    load_valid = 1'b0;
    load_start = 1'b0;
    if (cnt < tgt) check("ld_timeout", cnt, tgt);
    check("flush_creset", core_reset, 1);
    check("flush_done", load_done, 1);
    check("flush_halt", core_halt, 1);
    check("flush_ready", load_ready, 0);
    check("flush_ivld", instr_valid, 0);
    addr = 8'd0;
    tick();
    check("run_halt", core_halt, 0);
    check("run_creset", core_reset, 0);
    check("run_done", load_done, 0);
    check("run_ready", load_ready, 0);
    check("run_ivld0", instr_valid, 0);
    mlen = tgt;
    running = 1;
    read_chk(8'd0);
  endtask

  initial begin
    reset = 1'b1;
    addr = '0;
    load_start = 1'b0;
    load_len = '0;
    load_valid = 1'b0;
    load_data = '0;

    // Reset and idle
    for (int i = 0; i < 2; i++) begin
      tick();
      halted_chk("reset");
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      addr = 8'($urandom);
      tick();
      halted_chk("idle");
    end

    // Zero-length start from EMPTY is ignored
    load_start = 1'b1;
    load_len = 9'd0;
    tick();
    load_start = 1'b0;
    halted_chk("zero_start");

    // Basic 4-word load and reads
    words[0] = 9'h011; words[1] = 9'h022; words[2] = 9'h033; words[3] = 9'h044;
    do_load(4, 0, -1);
    for (int i = 0; i < 4; i++) read_chk(8'(i));
    read_chk(8'd4);
    read_chk(8'd255);
    check("oor_const", instr, 9'h1FF);

    // Zero-length start while running is ignored
    load_start = 1'b1;
    load_len = 9'd0;
    read_chk(8'd2);
    load_start = 1'b0;
    read_chk(8'd3);

    // Backpressured source
    for (int i = 0; i < 3; i++) words[i] = 9'($urandom);
    do_load(3, 2, -1);
    for (int i = 0; i < 5; i++) read_chk(8'(i));

    // Full-size load, clamped
    for (int i = 0; i < 256; i++) words[i] = 9'(i);
    do_load(300, 0, -1);
    read_chk(8'd255);
    check("full_255", instr, 9'h0FF);
    read_chk(8'd0);
    check("full_0", instr, 9'h000);
    for (int i = 0; i < 20; i++) read_chk(8'($urandom));

    // Random loads with random backpressure
    for (int n = 0; n < 4; n++) begin
      int l;
      l = $urandom_range(1, 40);
      for (int i = 0; i < l; i++) words[i] = 9'($urandom);
      do_load(l, 1, -1);
      for (int i = 0; i < 15; i++) read_chk(8'($urandom_range(0, 48)));
    end

    // Reset during load
    for (int i = 0; i < 5; i++) words[i] = 9'($urandom);
    do_load(5, 1, 2);
    for (int i = 0; i < 3; i++) begin
      addr = 8'($urandom);
      tick();
      halted_chk("post_abort");
    end
    words[0] = 9'h155;
    words[1] = 9'h0AA;
    do_load(2, 0, -1);
    read_chk(8'd0);
    read_chk(8'd1);
    read_chk(8'd2);
    check("after_abort_oor", instr, 9'h1FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
